game_select_ctrl: RTL and testbench
===================================

Name: game_select_ctrl

Overview:
- Top-level sequencer that shares one VGA pixel-write port, the buttons and the per-game resets among NGAMES game modules.
- Game modules have Left/Right/Reset/VGAx/VGAy/VGAcol/Quit-style interfaces.
- Provides a menu to choose a game and clears the screen before and after each game.
- Holds every non-running game in reset and routes button inputs and pixel writes only to and from the running game.

Parameters:
- NGAMES, 2, number of game modules (1..8).
- SELW, 3, width of the game index.
- XW, 8, VGA x coordinate width.
- YW, 7, VGA y coordinate width.
- CW, 3, colour width.
- XMAX, 159, last x coordinate of the clear sweep.
- YMAX, 119, last y coordinate of the clear sweep.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- KeyLeft  in  1  raw left button (level).
- KeyRight  in  1  raw right button (level).
- KeySelect  in  1  raw select/abort button (level).
- GameQuit  in  NGAMES  per-game quit request (level).
- GameX  in  NGAMES*XW  packed pixel x; game i at [i*XW +: XW].
- GameY  in  NGAMES*YW  packed pixel y; game i at [i*YW +: YW].
- GameCol  in  NGAMES*CW  packed pixel colour; game i at [i*CW +: CW].
- GameWrite  in  NGAMES  per-game pixel write strobe.
- GameReset  out  NGAMES  per-game synchronous reset, 1 = held.
- GameLeft  out  1  Left level to the running game.
- GameRight  out  1  Right level to the running game.
- VGAx  out  XW  pixel x to the plotter.
- VGAy  out  YW  pixel y to the plotter.
- VGAcol  out  CW  pixel colour to the plotter.
- VGAwrite  out  1  pixel write strobe.
- Cursor  out  SELW  currently highlighted or running game index.
- State  out  2  00 MENU, 01 CLEAR_IN, 10 RUN, 11 CLEAR_OUT.

Behaviour:
- Reset values:
  - State = MENU, Cursor = 0.
  - GameReset = all ones.
  - GameLeft = GameRight = 0.
  - VGAx = VGAy = VGAcol = 0, VGAwrite = 0.
  - Sweep counters = 0, edge-detect registers = 0.
- Reset asserted in any state, including mid-sweep or mid-game, takes effect on the next edge with the values above.
- Button edges: each key is registered once. A press is key high and previous sample low, so it is one cycle per press; holding a key gives no repeat.
- MENU:
  - VGAwrite = 0, all games in reset.
  - Left edge alone: Cursor decrements; 0 wraps to NGAMES-1.
  - Right edge alone: Cursor increments; NGAMES-1 wraps to 0.
  - Left and Right edges in the same cycle: no cursor change.
  - Select edge: go to CLEAR_IN, Cursor frozen. Select wins over a simultaneous Left/Right edge, so the cursor keeps its pre-edge value.
- CLEAR_IN / CLEAR_OUT:
  - Writes one pixel per cycle: VGAwrite = 1, VGAcol = 0, VGAx/VGAy = sweep counters.
  - x steps 0..XMAX; at XMAX, x returns to 0 and y increments.
  - The write at (XMAX, YMAX) is the last one, for exactly (XMAX+1)*(YMAX+1) writes.
  - The next cycle is CLEAR_IN -> RUN or CLEAR_OUT -> MENU, with counters back at 0.
  - Buttons are ignored. Edge registers keep sampling, so a key held through the sweep gives no edge afterwards.
- RUN:
  - GameReset[Cursor] = 0 from the first RUN cycle; every other bit stays 1.
  - GameLeft/GameRight = registered KeyLeft/KeyRight levels, 1-cycle latency, both passed as-is even when both are high.
  - VGAx/VGAy/VGAcol/VGAwrite = game Cursor's fields, registered, 1-cycle latency.
  - GameWrite and GameQuit of non-running games are ignored.
- Leaving RUN:
  - Exit triggers: GameQuit[Cursor] high or a Select edge.
  - On the next edge: State = CLEAR_OUT, GameReset = all ones, GameLeft = GameRight = 0.
  - The game's write in its final RUN cycle is still forwarded; no write from the game after that.
  - Quit and Select in the same cycle count as a single exit.
- NGAMES = 1: Left/Right edges in MENU are no-ops, Cursor stays 0.

Test Plan:
- Reset, then idle 10 cycles -> State=00, Cursor=0, GameReset=all ones, VGAwrite=0 on every cycle.
- NGAMES=3, Right edges x4, then Left edges x2 -> Cursor 1,2,0,1 then 0,2. Left held 20 cycles -> only one decrement.
- XMAX=3, YMAX=2, Select edge in MENU:
  - exactly 12 consecutive VGAwrite=1 cycles with col 0, order (0,0),(1,0),(2,0),(3,0),(0,1)...(3,2);
  - then State=10, GameReset=3'b110 for Cursor=0.
- RUN with Cursor=1, game1 write (5,7,col 6), game0 write (1,1,col 2) in the same cycle -> next cycle VGAx=5, VGAy=7, VGAcol=6, VGAwrite=1; game0's write never appears.
- RUN, GameQuit[0] pulsed while running game 1 -> no effect. GameQuit[1] pulsed -> next cycle State=11, GameReset=all ones; after 12 clear writes State=00, Cursor still 1.
- Reset asserted at write 5 of CLEAR_IN -> next cycle State=00, Cursor=0, VGAwrite=0. A new Select edge restarts the sweep at (0,0).

Source files
------------

// File: rtl/game_select_ctrl.sv
// game_select_ctrl
//   Top-level sequencer that shares one VGA pixel-write port, the buttons and
//   the per-game resets among NGAMES game modules. It offers a menu to pick a
//   game, clears the screen before and after each game, and holds every game
//   that is not running in reset.
//
//   All outputs are registered. The pixel port shows what the current state
//   produced one cycle earlier: a clear-sweep pixel, the running game's pixel,
//   or nothing. Because the pixel lags by one cycle, the running game's write
//   in its last RUN cycle still reaches the plotter in the first CLEAR_OUT
//   cycle, and the sweep's write at (XMAX,YMAX) appears in the first cycle
//   after the sweep state.
//
// Ports
//   Clock, Reset             clock, synchronous active-high reset
//   KeyLeft/Right/Select     raw button levels
//   GameQuit[NGAMES]         per-game quit request (level)
//   GameX/GameY/GameCol      packed per-game pixel fields, game i at [i*W +: W]
//   GameWrite[NGAMES]        per-game pixel write strobe
//   GameReset[NGAMES]        per-game reset, 1 = held in reset
//   GameLeft/GameRight       button levels passed to the running game
//   VGAx/VGAy/VGAcol/VGAwrite  pixel write port to the plotter
//   Cursor                   highlighted or running game index
//   State                    00 MENU, 01 CLEAR_IN, 10 RUN, 11 CLEAR_OUT
module game_select_ctrl #(
  parameter int NGAMES = 2,
  parameter int SELW   = 3,
  parameter int XW     = 8,
  parameter int YW     = 7,
  parameter int CW     = 3,
  parameter int XMAX   = 159,
  parameter int YMAX   = 119
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 KeyLeft,
  input  logic                 KeyRight,
  input  logic                 KeySelect,
  input  logic [NGAMES-1:0]    GameQuit,
  input  logic [NGAMES*XW-1:0] GameX,
  input  logic [NGAMES*YW-1:0] GameY,
  input  logic [NGAMES*CW-1:0] GameCol,
  input  logic [NGAMES-1:0]    GameWrite,
  output logic [NGAMES-1:0]    GameReset,
  output logic                 GameLeft,
  output logic                 GameRight,
  output logic [XW-1:0]        VGAx,
  output logic [YW-1:0]        VGAy,
  output logic [CW-1:0]        VGAcol,
  output logic                 VGAwrite,
  output logic [SELW-1:0]      Cursor,
  output logic [1:0]           State
);

  typedef enum logic [1:0] {
    MENU      = 2'b00,
    CLEAR_IN  = 2'b01,
    RUN       = 2'b10,
    CLEAR_OUT = 2'b11
  } state_t;

  state_t          st, st_nxt;
  logic [SELW-1:0] cur_nxt;
  logic            prev_l, prev_r, prev_s;
  logic            edge_l, edge_r, edge_s;
  logic [XW-1:0]   sx;
  logic [YW-1:0]   sy;
  logic            sweep_last;
  logic            clearing;

  // running game's fields, selected by Cursor
  logic [XW-1:0]   g_x;
  logic [YW-1:0]   g_y;
  logic [CW-1:0]   g_col;
  logic            g_wr;
  logic            g_quit;
  logic [NGAMES-1:0] grst_nxt;

  assign edge_l     = KeyLeft   & ~prev_l;
  assign edge_r     = KeyRight  & ~prev_r;
  assign edge_s     = KeySelect & ~prev_s;
  assign clearing   = (st == CLEAR_IN) || (st == CLEAR_OUT);
  assign sweep_last = (sx == XW'(XMAX)) && (sy == YW'(YMAX));
  assign State      = st;

  always_comb begin
    g_x    = '0;
    g_y    = '0;
    g_col  = '0;
    g_wr   = 1'b0;
    g_quit = 1'b0;
    for (int i = 0; i < NGAMES; i++) begin
      if (Cursor == SELW'(i)) begin
        g_x    = GameX[i*XW +: XW];
        g_y    = GameY[i*YW +: YW];
        g_col  = GameCol[i*CW +: CW];
        g_wr   = GameWrite[i];
        g_quit = GameQuit[i];
      end
    end
  end

  // Next state and cursor. Select wins over Left/Right in the menu; opposite
  // Left/Right edges in the same cycle cancel.
  always_comb begin
    st_nxt  = st;
    cur_nxt = Cursor;
    case (st)
      MENU: begin
        if (edge_s) begin
          st_nxt = CLEAR_IN;
        end else if (edge_l && !edge_r) begin
          cur_nxt = (Cursor == '0) ? SELW'(NGAMES - 1) : Cursor - SELW'(1);
        end else if (edge_r && !edge_l) begin
          cur_nxt = (Cursor == SELW'(NGAMES - 1)) ? '0 : Cursor + SELW'(1);
        end
      end
      CLEAR_IN:  if (sweep_last) st_nxt = RUN;
      RUN:       if (edge_s || g_quit) st_nxt = CLEAR_OUT;
      CLEAR_OUT: if (sweep_last) st_nxt = MENU;
      default:   st_nxt = MENU;
    endcase
  end

  // Only the running game is released, and only while the next state is RUN.
  always_comb begin
    grst_nxt = '1;
    for (int i = 0; i < NGAMES; i++) begin
      if ((st_nxt == RUN) && (Cursor == SELW'(i))) grst_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      st        <= MENU;
      Cursor    <= '0;
      prev_l    <= 1'b0;
      prev_r    <= 1'b0;
      prev_s    <= 1'b0;
      sx        <= '0;
      sy        <= '0;
      GameReset <= '1;
      GameLeft  <= 1'b0;
      GameRight <= 1'b0;
      VGAx      <= '0;
      VGAy      <= '0;
      VGAcol    <= '0;
      VGAwrite  <= 1'b0;
    end else begin
      st        <= st_nxt;
      Cursor    <= cur_nxt;
      // edge registers sample in every state so a key held through a sweep
      // does not produce a press afterwards
      prev_l    <= KeyLeft;
      prev_r    <= KeyRight;
      prev_s    <= KeySelect;
      GameReset <= grst_nxt;
      GameLeft  <= (st_nxt == RUN) ? KeyLeft  : 1'b0;
      GameRight <= (st_nxt == RUN) ? KeyRight : 1'b0;

      // sweep counters: raster order, back to (0,0) after the last pixel
      if (clearing) begin
        if (sx == XW'(XMAX)) begin
          sx <= '0;
          sy <= sweep_last ? '0 : sy + YW'(1);
        end else begin
          sx <= sx + XW'(1);
        end
      end else begin
        sx <= '0;
        sy <= '0;
      end

      // pixel port
      if (clearing) begin
        VGAx     <= sx;
        VGAy     <= sy;
        VGAcol   <= '0;
        VGAwrite <= 1'b1;
      end else if (st == RUN) begin
        VGAx     <= g_x;
        VGAy     <= g_y;
        VGAcol   <= g_col;
        VGAwrite <= g_wr;
      end else begin
        VGAx     <= '0;
        VGAy     <= '0;
        VGAcol   <= '0;
        VGAwrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_game_select_ctrl.sv
module tb_game_select_ctrl;

  localparam int NG   = 3;
  localparam int SELW = 3;
  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int CW   = 3;
  localparam int XMAX = 3;
  localparam int YMAX = 2;
  localparam int NPIX = (XMAX + 1) * (YMAX + 1);

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              KeyLeft = 1'b0, KeyRight = 1'b0, KeySelect = 1'b0;
  logic [NG-1:0]     GameQuit = '0;
  logic [NG*XW-1:0]  GameX = '0;
  logic [NG*YW-1:0]  GameY = '0;
  logic [NG*CW-1:0]  GameCol = '0;
  logic [NG-1:0]     GameWrite = '0;
  logic [NG-1:0]     GameReset;
  logic              GameLeft, GameRight;
  logic [XW-1:0]     VGAx;
  logic [YW-1:0]     VGAy;
  logic [CW-1:0]     VGAcol;
  logic              VGAwrite;
  logic [SELW-1:0]   Cursor;
  logic [1:0]        State;

  game_select_ctrl #(
    .NGAMES(NG), .SELW(SELW), .XW(XW), .YW(YW), .CW(CW), .XMAX(XMAX), .YMAX(YMAX)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .KeyLeft(KeyLeft), .KeyRight(KeyRight), .KeySelect(KeySelect),
    .GameQuit(GameQuit), .GameX(GameX), .GameY(GameY), .GameCol(GameCol),
    .GameWrite(GameWrite), .GameReset(GameReset),
    .GameLeft(GameLeft), .GameRight(GameRight),
    .VGAx(VGAx), .VGAy(VGAy), .VGAcol(VGAcol), .VGAwrite(VGAwrite),
    .Cursor(Cursor), .State(State)
  );

  always #5 Clock = ~Clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 menu, 1 clear-in, 2 run, 3 clear-out.
  // k counts sweep pixels already issued in the current sweep.
  int            m_mode = 0, m_cur = 0, m_k = 0;
  bit            m_pl = 0, m_pr = 0, m_ps = 0;
  int            e_x = 0, e_y = 0, e_col = 0;
  bit            e_wr = 0, e_gl = 0, e_gr = 0;
  logic [NG-1:0] e_grst = '1;

  function void model_step();
    bit lp, rp, sp;
    if (Reset) begin
      m_mode = 0; m_cur = 0; m_k = 0;
      m_pl = 0; m_pr = 0; m_ps = 0;
      e_x = 0; e_y = 0; e_col = 0; e_wr = 0; e_gl = 0; e_gr = 0;
      e_grst = '1;
      return;
    end
    lp = KeyLeft && !m_pl;
    rp = KeyRight && !m_pr;
    sp = KeySelect && !m_ps;
    // pixel produced this cycle, visible after the edge
    if (m_mode == 1 || m_mode == 3) begin
      e_x = m_k % (XMAX + 1); e_y = m_k / (XMAX + 1); e_col = 0; e_wr = 1;
    end else if (m_mode == 2) begin
      e_x = int'(GameX[m_cur*XW +: XW]);
      e_y = int'(GameY[m_cur*YW +: YW]);
      e_col = int'(GameCol[m_cur*CW +: CW]);
      e_wr = GameWrite[m_cur];
    end else begin
      e_x = 0; e_y = 0; e_col = 0; e_wr = 0;
    end
    case (m_mode)
      0: begin
        if (sp) begin
          m_mode = 1; m_k = 0;
        end else if (lp && !rp) m_cur = (m_cur + NG - 1) % NG;
        else if (rp && !lp) m_cur = (m_cur + 1) % NG;
      end
      1, 3: begin
        m_k++;
        if (m_k == NPIX) begin
          m_k = 0;
          m_mode = (m_mode == 1) ? 2 : 0;
        end
      end
      default: if (sp || GameQuit[m_cur]) m_mode = 3;
    endcase
    e_grst = '1;
    if (m_mode == 2) e_grst[m_cur] = 1'b0;
    e_gl = (m_mode == 2) ? KeyLeft : 1'b0;
    e_gr = (m_mode == 2) ? KeyRight : 1'b0;
    m_pl = KeyLeft; m_pr = KeyRight; m_ps = KeySelect;
  endfunction

  task automatic check_all();
    chk("state", 32'(State), 32'(m_mode));
    chk("cursor", 32'(Cursor), 32'(m_cur));
    chk("game_reset", 32'(GameReset), 32'(e_grst));
    chk("game_left", 32'(GameLeft), 32'(e_gl));
    chk("game_right", 32'(GameRight), 32'(e_gr));
    chk("vga_write", 32'(VGAwrite), 32'(e_wr));
    chk("vga_x", 32'(VGAx), 32'(e_x));
    chk("vga_y", 32'(VGAy), 32'(e_y));
    chk("vga_col", 32'(VGAcol), 32'(e_col));
  endtask

  task automatic step();
    model_step();
    @(negedge Clock);
    check_all();
  endtask

  task automatic press_right();
    KeyRight = 1'b1; step(); KeyRight = 1'b0; step();
  endtask

  task automatic press_left();
    KeyLeft = 1'b1; step(); KeyLeft = 1'b0; step();
  endtask

  task automatic press_select();
    KeySelect = 1'b1; step(); KeySelect = 1'b0; step();
  endtask

  task automatic wait_mode(input int target, input int budget, input string tag);
    int n = 0;
    while (m_mode != target && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(m_mode == target), 32'd1);
  endtask

  task automatic set_game(input int g, input int x, input int y, input int c, input bit w);
    GameX[g*XW +: XW]   = XW'(x);
    GameY[g*YW +: YW]   = YW'(y);
    GameCol[g*CW +: CW] = CW'(c);
    GameWrite[g]        = w;
  endtask

  initial begin
    // reset and idle
    repeat (2) step();
    Reset = 1'b0;
    repeat (10) step();

    // cursor movement with wrap, held key gives one decrement
    repeat (4) press_right();
    repeat (2) press_left();
    KeyLeft = 1'b1;
    repeat (20) step();
    KeyLeft = 1'b0;
    step();
    chk("cursor_after_moves", 32'(Cursor), 32'd1);

    // simultaneous left+right edges: no change
    KeyLeft = 1'b1; KeyRight = 1'b1; step();
    KeyLeft = 1'b0; KeyRight = 1'b0; step();

    // run game 1, with select colliding with a right edge
    KeyRight = 1'b1; KeySelect = 1'b1; step();
    KeyRight = 1'b0; KeySelect = 1'b0; step();
    wait_mode(2, 40, "enter_run");
    set_game(1, 5, 7, 6, 1'b1);
    set_game(0, 1, 1, 2, 1'b1);
    step();
    set_game(1, 0, 0, 0, 1'b0);
    set_game(0, 0, 0, 0, 1'b0);
    step();
    KeyLeft = 1'b1; step(); step(); KeyLeft = 1'b0; step();
    GameQuit = 3'b001; step(); GameQuit = '0; step();
    GameQuit = 3'b010; set_game(1, 2, 3, 4, 1'b1); step();
    GameQuit = '0; set_game(1, 0, 0, 0, 1'b0); step();
    wait_mode(0, 40, "back_to_menu");
    chk("cursor_kept", 32'(Cursor), 32'd1);

    // reset in the middle of the entry sweep, then a fresh sweep
    press_select();
    repeat (4) step();
    Reset = 1'b1; step(); Reset = 1'b0; step();
    chk("reset_mid_sweep", 32'(State), 32'd0);
    press_select();
    wait_mode(2, 40, "rerun");
    press_select();
    wait_mode(0, 40, "abort_run");

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      KeyLeft   = ($urandom_range(0, 3) == 0);
      KeyRight  = ($urandom_range(0, 3) == 0);
      KeySelect = ($urandom_range(0, 9) == 0);
      for (int g = 0; g < NG; g++) begin
        GameQuit[g] = ($urandom_range(0, 29) == 0);
        set_game(g, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
      end
      Reset = ($urandom_range(0, 299) == 0);
      step();
    end
    Reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
